// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I decode stage with register file, immediate generation and ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback data onto the read ports.
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int IMM_WIDTH = 32,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_instr,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 wb_en,
  input  logic [RW-1:0]        wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 ex_is_load,
  input  logic [RW-1:0]        ex_rd,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_rs1_data,
  output logic [XLEN-1:0]      out_rs2_data,
  output logic [IMM_WIDTH-1:0] out_imm,
  output logic [RW-1:0]        out_rd,
  output logic [RW-1:0]        out_rs1,
  output logic [RW-1:0]        out_rs2,
  output logic [6:0]           out_opcode,
  output logic [2:0]           out_funct3,
  output logic [6:0]           out_funct7
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [RW-1:0] rd, rs1, rs2;
  logic [XLEN-1:0] regs [NUM_REGS];
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [31:0] imm32;
  logic is_i, is_s, is_b, is_u, is_j, is_r;
  logic rs1_used, rs2_used, hazard, adv, load;
  assign opcode = in_instr[6:0];
  assign rd     = in_instr[7 +: RW];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[15 +: RW];
  assign rs2    = in_instr[20 +: RW];
  assign funct7 = in_instr[31:25];
  assign is_i = opcode == 7'b0000011 || opcode == 7'b0010011 || opcode == 7'b1100111;
  assign is_s = opcode == 7'b0100011;
  assign is_b = opcode == 7'b1100011;
  assign is_u = opcode == 7'b0110111 || opcode == 7'b0010111;
  assign is_j = opcode == 7'b1101111;
  assign is_r = opcode == 7'b0110011;
  assign rs1_used = !is_u && !is_j;
  assign rs2_used = is_r || is_s || is_b;
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (wb_en && wb_rd != '0) regs[wb_rd] <= wb_data;
  always_comb begin
`ifdef ID_WB_BYPASS_EN
    rs1_data = rs1 == '0 ? '0 : (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
    rs2_data = rs2 == '0 ? '0 : (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
`else
    rs1_data = rs1 == '0 ? '0 : regs[rs1];
    rs2_data = rs2 == '0 ? '0 : regs[rs2];
`endif
  end
  always_comb
    imm32 = is_i ? {{20{in_instr[31]}}, in_instr[31:20]} :
            is_s ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
            is_b ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
            is_u ? {in_instr[31:12], 12'b0} :
            is_j ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
            32'b0;
  assign hazard = in_valid && ex_is_load && ex_rd != '0 &&
                  ((ex_rd == rs1 && rs1_used) || (ex_rd == rs2 && rs2_used));
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !hazard && !flush;
  assign load     = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7   <= '0;
    end else begin
      if (flush || adv) out_valid <= load;
      if (load) begin
        out_pc       <= in_pc;
        out_rs1_data <= rs1_data;
        out_rs2_data <= rs2_data;
        out_imm      <= IMM_WIDTH'($signed(imm32));
        out_rd       <= rd;
        out_rs1      <= rs1;
        out_rs2      <= rs2;
        out_opcode   <= opcode;
        out_funct3   <= funct3;
        out_funct7   <= funct7;
      end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: scoreboard bench for id_stage_pipe against a transaction-level model.
module tb_id_stage_pipe;
  typedef struct packed {
    logic [31:0] pc, a, b, imm;
    logic [4:0] rd, r1, r2;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
  } exp_t;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, wb_en = 0, ex_is_load = 0, flush = 0, out_valid, out_ready = 1;
  logic [31:0] in_instr = 0, in_pc = 0, wb_data = 0;
  logic [4:0] wb_rd = 0, ex_rd = 0;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [6:0] out_opcode, out_funct7;
  logic [2:0] out_funct3;
  exp_t got, q[$];
  logic [31:0] mregs [32];
  logic m_ov = 0;
  int n_vec = 0, n_err = 0;
  logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h33, 7'h0f, 7'h73};
  id_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7)
  );
  assign got = {out_pc, out_rs1_data, out_rs2_data, out_imm, out_rd, out_rs1, out_rs2,
                out_opcode, out_funct3, out_funct7};
  always #5 clk = ~clk;
  function automatic logic [31:0] imm_of(input logic [31:0] x);
    case (x[6:0])
      7'h03, 7'h13, 7'h67: return 32'($signed(x[31:20]));
      7'h23: return 32'($signed({x[31:25], x[11:7]}));
      7'h63: return 32'($signed({x[31], x[7], x[30:25], x[11:8]})) * 2;
      7'h37, 7'h17: return x & 32'hFFFFF000;
      7'h6f: return 32'($signed({x[31], x[19:12], x[20], x[30:21]})) * 2;
      default: return 0;
    endcase
  endfunction
  function automatic logic [31:0] rdm(input logic [4:0] r, input logic we, input logic [4:0] wr,
                                      input logic [31:0] wd);
    if (r == 0) return 0;
`ifdef ID_WB_BYPASS_EN
    if (we && wr == r) return wd;
`endif
    return mregs[r];
  endfunction
  task automatic cyc(input logic v, input logic [31:0] ins, pc, input logic we, input logic [4:0] wr,
                     input logic [31:0] wd, input logic el, input logic [4:0] er, input logic fl,
                     input logic ordy);
    logic [4:0] r1, r2;
    logic [6:0] op;
    logic u1, u2, hz, adv, rdy;
    exp_t e;
    @(posedge clk);
    #2;
    in_valid = v; in_instr = ins; in_pc = pc; wb_en = we; wb_rd = wr; wb_data = wd;
    ex_is_load = el; ex_rd = er; flush = fl; out_ready = ordy;
    #1;
    op = ins[6:0]; r1 = ins[19:15]; r2 = ins[24:20];
    u1 = !(op inside {7'h37, 7'h17, 7'h6f});
    u2 = op inside {7'h33, 7'h23, 7'h63};
    hz = v && el && er != 0 && ((er == r1 && u1) || (er == r2 && u2));
    adv = !m_ov || ordy;
    rdy = adv && !hz && !fl;
    n_vec++;
    if (in_ready !== rdy) begin
      n_err++;
      $display("FAIL in_ready t=%0t got=%b want=%b", $time, in_ready, rdy);
    end
    n_vec++;
    if (out_valid !== m_ov) begin
      n_err++;
      $display("FAIL out_valid t=%0t got=%b want=%b", $time, out_valid, m_ov);
    end
    if (fl) begin
      if (m_ov && !ordy) void'(q.pop_back());
      m_ov = 0;
    end else if (adv) begin
      m_ov = v && !hz;
      if (m_ov) begin
        e = '{pc: pc, a: rdm(r1, we, wr, wd), b: rdm(r2, we, wr, wd), imm: imm_of(ins),
              rd: ins[11:7], r1: r1, r2: r2, op: op, f3: ins[14:12], f7: ins[31:25]};
        q.push_back(e);
      end
    end
    if (we && wr != 0) mregs[wr] = wd;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 0;
    q.delete();
    m_ov = 0;
    foreach (mregs[i]) mregs[i] = 0;
    #1;
    n_vec++;
    if (out_valid !== 0 || got !== '0) begin
      n_err++;
      $display("FAIL reset_state got_valid=%b got=%h want all zero", out_valid, got);
    end
    @(posedge clk);
    #2;
    rst = 1;
  endtask
  always @(negedge clk)
    if (rst && out_valid && out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output t=%0t got=%h want=none", $time, got);
      end else if (got !== q[0]) begin
        n_err++;
        $display("FAIL out_fields t=%0t got=%h want=%h", $time, got, q[0]);
        void'(q.pop_front());
      end else void'(q.pop_front());
    end
  initial begin
    logic [31:0] ins;
    foreach (mregs[i]) mregs[i] = 0;
    #13;
    n_vec++;
    if (out_valid !== 0 || got !== '0) begin
      n_err++;
      $display("FAIL initial_reset got_valid=%b got=%h want all zero", out_valid, got);
    end
    rst = 1;
    cyc(0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 1);
    cyc(1, 32'hFFF28313, 32'h100, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 1);
    cyc(1, 32'h00500093, 32'h104, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h001283B3, 32'h108, 0, 0, 0, 1, 5, 0, 1);
    cyc(1, 32'h001283B3, 32'h108, 0, 0, 0, 0, 5, 0, 1);
    cyc(1, 32'h00500093, 32'h10c, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) cyc(1, 32'hFFF28313, 32'h110, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'hFFF28313, 32'h110, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 32'h001283B3, 32'h114, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 9, 32'h77, 0, 0, 0, 1);
    cyc(1, 32'h00048513, 32'h118, 1, 9, 32'hABCD, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 500; i++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 11)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      cyc($urandom_range(0, 9) < 8, ins, $urandom, $urandom_range(0, 1), 5'($urandom_range(0, 7)),
          $urandom, $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) < 7);
    end
    cyc(1, 32'h00500093, 32'h200, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    cyc(1, 32'h001283B3, 32'h300, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Pipelined successor of the single-cycle decode unit for the RV32I core. It decodes the instruction, reads the integer register file, generates the immediate, and registers everything into an ID/EX pipeline register. It adds a valid/ready handshake, a writeback port, load-use hazard stalling and a flush. The block sits between the IF and EX pipeline stages.

Parameters:
XLEN, 32, instruction/data/PC width
NUM_REGS, 32, register count; rs/rd index width = clog2(NUM_REGS)
IMM_WIDTH, 32, immediate output width (sign-extended)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  IF has an instruction
in_ready  out  1  ID accepts the instruction this cycle
in_instr  in  XLEN  instruction word
in_pc  in  XLEN  PC of in_instr
wb_en  in  1  writeback enable
wb_rd  in  RW  writeback destination index (RW = clog2(NUM_REGS))
wb_data  in  XLEN  writeback data
ex_is_load  in  1  instruction currently in EX is a load
ex_rd  in  RW  destination of the instruction in EX
flush  in  1  kill the in-flight decode (branch taken)
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  EX accepts the instruction
out_pc  out  XLEN  registered PC
out_rs1_data  out  XLEN  registered rs1 value
out_rs2_data  out  XLEN  registered rs2 value
out_imm  out  IMM_WIDTH  registered immediate
out_rd, out_rs1, out_rs2  out  RW each  registered register indices
out_opcode  out  7  registered opcode
out_funct3  out  3  registered funct3
out_funct7  out  7  registered funct7

Behaviour:
- Field extraction: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- Register file: NUM_REGS x XLEN, two combinational read ports and one synchronous write port. x0 reads 0. Writes to x0 are ignored. Register contents are cleared to 0 on reset.
- Immediate by opcode, sign-extended to IMM_WIDTH:
  - I (0000011, 0010011, 1100111): instr[31:20]
  - S (0100011): {instr[31:25], instr[11:7]}
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U (0110111, 0010111): {instr[31:12], 12'b0}
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - Any other opcode: 0.
- rs1 is used by every opcode except U and J. rs2 is used by R (0110011), S and B.
- hazard = in_valid & ex_is_load & (ex_rd != 0) & ((ex_rd == rs1 & rs1_used) | (ex_rd == rs2 & rs2_used)).
- adv = !out_valid | out_ready.
- in_ready = adv & !hazard & !flush.
- Each clock edge:
  - If flush: out_valid <= 0. The input is not accepted.
  - Else if adv and in_valid and !hazard: load all out_* fields, out_valid <= 1.
  - Else if adv: out_valid <= 0 (bubble on hazard or idle). Hold on hazard lasts exactly as long as the hazard condition is asserted.
  - Else (out_valid & !out_ready): hold all out_* fields unchanged.
- Latency: accepted instruction appears on out_* one cycle later.
- Reset (rst = 0, asynchronous): out_valid = 0, all out_* = 0, register file = 0. Reset asserted mid-stall discards the held instruction.
- flush together with wb_en: the write still occurs. flush has priority over hazard and acceptance.
- wb_en together with read of the same index: see ID_WB_BYPASS_EN.

Optional Feature:
Macro ID_WB_BYPASS_EN.
- Defined: when wb_en and wb_rd != 0 match rs1 or rs2, the read port returns wb_data in the same cycle, so the value latched into out_rsX_data is the new value.
- Undefined: the read returns the pre-write register value. The writer stage must then avoid that collision.

Test Plan:
- Reset, then write x5=0x1234 via wb, then accept "addi x6,x5,-1" (0xFFF28313) -> next cycle out_valid=1, out_rs1_data=0x1234, out_imm=0xFFFFFFFF, out_rd=6.
- Write x0=0xDEAD, then decode rs1=x0 -> out_rs1_data=0.
- ex_is_load=1, ex_rd=5, in_instr "add x7,x5,x1" -> in_ready=0 and a bubble (out_valid=0) for 1 cycle; ex_is_load=0 next cycle -> instruction accepted.
- out_ready=0 with out_valid=1 for 3 cycles -> out_* stable, in_ready=0; out_ready=1 -> next instruction advances.
- flush=1 while in_valid=1 -> out_valid=0 next cycle, instruction dropped. Same-cycle wb of x9 with decode of rs1=x9 -> wb_data latched with ID_WB_BYPASS_EN, old value without.
